// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder.
// Phase encoding is {a, b}; forward order is 00 -> 10 -> 11 -> 01 -> 00.
package quad_pkg;

    typedef enum logic {QD_INIT, QD_RUN} qd_state_t;

    typedef logic [1:0] qphase_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic qphase_t phase_fwd(qphase_t p);
        return {~p[0], p[1]};
    endfunction

    function automatic qphase_t phase_rev(qphase_t p);
        return {p[0], ~p[1]};
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit resynchroniser: SYNC_STAGES async-reset flops in series.
module sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: resynchronises the phases, emits step/direction pulses,
// keeps a wrapping position count and flags illegal double transitions.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             cnt_clr,
    input  logic             a_in,
    input  logic             b_in,
    output logic             step,
    output logic             up_down,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned INIT_W = $clog2(SYNC_STAGES + 1) + 1;

    logic        a_s;
    logic        b_s;
    qphase_t     cur;

    qd_state_t   state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    qphase_t     prev_q;
    logic        step_q, step_d;
    logic        up_down_q, up_down_d;
    logic        err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_a (
        .clk   (clk),
        .clr_n (clr_n),
        .d     (a_in),
        .q     (a_s)
    );

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_b (
        .clk   (clk),
        .clr_n (clr_n),
        .d     (b_in),
        .q     (b_s)
    );

    assign cur = {a_s, b_s};

    // INIT lasts until the synchroniser has flushed its reset zeros, so the
    // pin state present at release is absorbed into prev rather than decoded.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        step_d     = 1'b0;
        err_d      = 1'b0;
        up_down_d  = up_down_q;
        count_d    = count_q;

        unique case (state_q)
            QD_INIT: begin
                if (init_cnt_q == INIT_W'(SYNC_STAGES)) begin
                    state_d = QD_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            QD_RUN: begin
                if (en) begin
                    if (cur == phase_fwd(prev_q)) begin
                        step_d    = 1'b1;
                        up_down_d = DIR_UP;
                        count_d   = count_q + CNT_W'(1);
                    end else if (cur == phase_rev(prev_q)) begin
                        step_d    = 1'b1;
                        up_down_d = DIR_DN;
                        count_d   = count_q - CNT_W'(1);
                    end else if (cur == ~prev_q) begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase

        if (cnt_clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= QD_INIT;
            init_cnt_q <= '0;
            prev_q     <= 2'b00;
            step_q     <= 1'b0;
            up_down_q  <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_q     <= cur;
            step_q     <= step_d;
            up_down_q  <= up_down_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign step    = step_q;
    assign up_down = up_down_q;
    assign err     = err_q;
    assign count   = count_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder (CNT_W=16, SYNC_STAGES=2).
module tb_quad_decoder;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             clr_n;
    logic             en;
    logic             cnt_clr;
    logic             a_in;
    logic             b_in;
    logic             step;
    logic             up_down;
    logic             err;
    logic [CNT_W-1:0] count;

    int total;
    int bad;
    int step_seen;
    int err_seen;

    quad_decoder #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .en      (en),
        .cnt_clr (cnt_clr),
        .a_in    (a_in),
        .b_in    (b_in),
        .step    (step),
        .up_down (up_down),
        .err     (err),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle pulses are sampled once each, away from the rising edge.
    initial begin
        step_seen = 0;
        err_seen  = 0;
    end
    always @(negedge clk) begin
        if (clr_n && step) step_seen = step_seen + 1;
        if (clr_n && err)  err_seen  = err_seen + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_phase(input logic [1:0] p, input int n);
        @(negedge clk);
        {a_in, b_in} = p;
        wait_clk(n);
    endtask

    task automatic pulse_cnt_clr();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        wait_clk(1);
    endtask

    task automatic test_reset();
        int s0, e0;
        clr_n = 1'b0; en = 1'b1; cnt_clr = 1'b0; a_in = 1'b1; b_in = 1'b1;
        #23;
        @(negedge clk);
        clr_n = 1'b1;
        s0 = step_seen; e0 = err_seen;
        wait_clk(10);
        total++;
        if (step_seen - s0 !== 0) begin
            bad++; $display("FAIL reset_steps: got %0d want 0", step_seen - s0);
        end
        total++;
        if (err_seen - e0 !== 0) begin
            bad++; $display("FAIL reset_errs: got %0d want 0", err_seen - e0);
        end
        total++;
        if (count !== 16'h0000) begin
            bad++; $display("FAIL reset_count: got %h want 0000", count);
        end
        total++;
        if (up_down !== 1'b0) begin
            bad++; $display("FAIL reset_up_down: got %b want 0", up_down);
        end
    endtask

    task automatic test_forward();
        int s0, e0;
        // Walk 11 -> 10 -> 00 (two reverse steps), then clear to start at zero.
        set_phase(2'b10, 8);
        set_phase(2'b00, 8);
        total++;
        if (count !== 16'hFFFE) begin
            bad++; $display("FAIL pre_fwd_count: got %h want fffe", count);
        end
        pulse_cnt_clr();
        total++;
        if (count !== 16'h0000) begin
            bad++; $display("FAIL cnt_clr_count: got %h want 0000", count);
        end
        s0 = step_seen; e0 = err_seen;
        @(negedge clk);
        a_in = 1'b1;
        wait_clk(1);
        total++;
        if (step !== 1'b0) begin
            bad++; $display("FAIL latency_edge1: got step=%b want 0", step);
        end
        wait_clk(1);
        total++;
        if (step !== 1'b0) begin
            bad++; $display("FAIL latency_edge2: got step=%b want 0", step);
        end
        wait_clk(1);
        total++;
        if (step !== 1'b1 || up_down !== 1'b1 || count !== 16'h0001) begin
            bad++;
            $display("FAIL latency_edge3: got step=%b up=%b cnt=%h want 1 1 0001",
                     step, up_down, count);
        end
        wait_clk(5);
        set_phase(2'b11, 8);
        set_phase(2'b01, 8);
        set_phase(2'b00, 8);
        total++;
        if (step_seen - s0 !== 4) begin
            bad++; $display("FAIL fwd_steps: got %0d want 4", step_seen - s0);
        end
        total++;
        if (up_down !== 1'b1 || count !== 16'h0004 || err_seen - e0 !== 0) begin
            bad++;
            $display("FAIL fwd_state: got up=%b cnt=%h errs=%0d want 1 0004 0",
                     up_down, count, err_seen - e0);
        end
    endtask

    task automatic test_reverse();
        int s0, e0;
        pulse_cnt_clr();
        s0 = step_seen; e0 = err_seen;
        set_phase(2'b01, 8);
        set_phase(2'b11, 8);
        set_phase(2'b10, 8);
        set_phase(2'b00, 8);
        total++;
        if (step_seen - s0 !== 4) begin
            bad++; $display("FAIL rev_steps: got %0d want 4", step_seen - s0);
        end
        total++;
        if (up_down !== 1'b0 || count !== 16'hFFFC || err_seen - e0 !== 0) begin
            bad++;
            $display("FAIL rev_state: got up=%b cnt=%h errs=%0d want 0 fffc 0",
                     up_down, count, err_seen - e0);
        end
    endtask

    task automatic test_err_and_enable();
        int s0, e0;
        s0 = step_seen; e0 = err_seen;
        set_phase(2'b11, 8);
        total++;
        if (err_seen - e0 !== 1 || step_seen - s0 !== 0) begin
            bad++;
            $display("FAIL double_jump: got errs=%0d steps=%0d want 1 0",
                     err_seen - e0, step_seen - s0);
        end
        total++;
        if (count !== 16'hFFFC || up_down !== 1'b0) begin
            bad++; $display("FAIL err_hold: got cnt=%h up=%b want fffc 0", count, up_down);
        end
        s0 = step_seen; e0 = err_seen;
        @(negedge clk);
        en = 1'b0;
        set_phase(2'b01, 8);
        set_phase(2'b00, 8);
        set_phase(2'b10, 8);
        total++;
        if (step_seen - s0 !== 0 || count !== 16'hFFFC || up_down !== 1'b0) begin
            bad++;
            $display("FAIL en_low: got steps=%0d cnt=%h up=%b want 0 fffc 0",
                     step_seen - s0, count, up_down);
        end
        @(negedge clk);
        en = 1'b1;
        wait_clk(8);
        total++;
        if (step_seen - s0 !== 0 || err_seen - e0 !== 0 || count !== 16'hFFFC) begin
            bad++;
            $display("FAIL reenable: got steps=%0d errs=%0d cnt=%h want 0 0 fffc",
                     step_seen - s0, err_seen - e0, count);
        end
    endtask

    task automatic test_clr_overrides_step();
        pulse_cnt_clr();
        set_phase(2'b11, 8);
        set_phase(2'b01, 8);
        set_phase(2'b00, 8);
        set_phase(2'b10, 8);
        set_phase(2'b11, 8);
        set_phase(2'b01, 8);
        set_phase(2'b00, 8);
        total++;
        if (count !== 16'h0007) begin
            bad++; $display("FAIL count_seven: got %h want 0007", count);
        end
        @(negedge clk);
        a_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cnt_clr = 1'b1;
        wait_clk(1);
        total++;
        if (step !== 1'b1 || up_down !== 1'b1 || count !== 16'h0000) begin
            bad++;
            $display("FAIL clr_vs_step: got step=%b up=%b cnt=%h want 1 1 0000",
                     step, up_down, count);
        end
        @(negedge clk);
        cnt_clr = 1'b0;
        wait_clk(4);
        total++;
        if (count !== 16'h0000) begin
            bad++; $display("FAIL clr_after: got %h want 0000", count);
        end
    endtask

    task automatic test_async_reset();
        int s0;
        set_phase(2'b11, 8);
        total++;
        if (count !== 16'h0001 || up_down !== 1'b1) begin
            bad++; $display("FAIL pre_reset: got cnt=%h up=%b want 0001 1", count, up_down);
        end
        @(negedge clk);
        {a_in, b_in} = 2'b01;
        @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        total++;
        if (step !== 1'b0 || err !== 1'b0 || up_down !== 1'b0 || count !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset: got step=%b err=%b up=%b cnt=%h want 0 0 0 0000",
                     step, err, up_down, count);
        end
        @(negedge clk);
        clr_n = 1'b1;
        s0 = step_seen;
        wait_clk(8);
        total++;
        if (step_seen - s0 !== 0 || count !== 16'h0000) begin
            bad++;
            $display("FAIL post_release: got steps=%0d cnt=%h want 0 0000",
                     step_seen - s0, count);
        end
        set_phase(2'b00, 8);
        total++;
        if (step_seen - s0 !== 1 || count !== 16'h0001 || up_down !== 1'b1) begin
            bad++;
            $display("FAIL first_after_reset: got steps=%0d cnt=%h up=%b want 1 0001 1",
                     step_seen - s0, count, up_down);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_forward();
        test_reverse();
        test_err_and_enable();
        test_clr_overrides_step();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
